// File: rtl/sync_test_sequencer.sv
// rtl/sync_test_sequencer.sv - drives patterns through a synchronizer channel and checks the toggle-acknowledged return data
// Optional first-error capture ports are enabled by defining ERR_CAPTURE_EN.
module sync_test_sequencer #(
  parameter int N        = 8,
  parameter int NUM_XFER = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   chan,
  input  logic         ack_in,
  input  logic [N-1:0] rx_data,
  output logic [N-1:0] tx_data,
  output logic         stb_out,
  output logic [2:0]   sel_out,
  output logic         busy,
  output logic         done,
  output logic [7:0]   err_cnt,
  output logic         timeout_flag
`ifdef ERR_CAPTURE_EN
  ,
  output logic [N-1:0] first_err_data,
  output logic [7:0]   first_err_idx
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STROBE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [N-1:0] PAT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nx;
  logic         ack_s1, ack_s2, ack_prev;
  logic         ack_evt;
  logic [N-1:0] pattern;
  logic [N-1:0] cap_data;
  logic [7:0]   idx;
  logic [9:0]   wait_cnt;
  logic         timed_out;
  logic         wait_expired;
  logic         last_xfer;
  logic         mismatch;
  logic [7:0]   err_inc;

  // Two-flop synchronizer plus one history flop; either edge of the second flop is an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_s1   <= ack_in;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  assign ack_evt      = ack_s2 ^ ack_prev;
  assign wait_expired = ({1'b0, wait_cnt} + 11'd1) == 11'(TIMEOUT);
  assign last_xfer    = ({1'b0, idx} + 9'd1) >= 9'(NUM_XFER);
  assign mismatch     = !timed_out && (cap_data != pattern);
  assign err_inc      = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_STROBE;
      S_STROBE: state_nx = S_WAIT;
      S_WAIT:   if (ack_evt || wait_expired) state_nx = S_CHECK;
      S_CHECK:  state_nx = last_xfer ? S_DONE : S_LOAD;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign stb_out = (state == S_STROBE);
  assign done    = (state == S_DONE);

`ifdef ERR_CAPTURE_EN
  logic err_seen;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data      <= '0;
      sel_out      <= '0;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
      pattern      <= '0;
      cap_data     <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      timed_out    <= 1'b0;
`ifdef ERR_CAPTURE_EN
      err_seen       <= 1'b0;
      first_err_data <= '0;
      first_err_idx  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sel_out      <= chan;
          err_cnt      <= '0;
          timeout_flag <= 1'b0;
          idx          <= '0;
          pattern      <= PAT_ONE;
`ifdef ERR_CAPTURE_EN
          err_seen       <= 1'b0;
          first_err_data <= '0;
          first_err_idx  <= '0;
`endif
        end
        S_LOAD: tx_data <= pattern;
        S_STROBE: begin
          wait_cnt  <= '0;
          timed_out <= 1'b0;
        end
        // An ack landing on the expiry cycle wins over the timeout.
        S_WAIT: begin
          if (ack_evt) begin
            cap_data <= rx_data;
          end else if (wait_expired) begin
            timed_out    <= 1'b1;
            timeout_flag <= 1'b1;
            err_cnt      <= err_inc;
          end else begin
            wait_cnt <= wait_cnt + 10'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_inc;
`ifdef ERR_CAPTURE_EN
            if (!err_seen) begin
              err_seen       <= 1'b1;
              first_err_data <= cap_data;
              first_err_idx  <= idx;
            end
`endif
          end
          idx     <= idx + 8'd1;
          pattern <= pattern + PAT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
